// File: rtl/hsi_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : hsi_tx_sequencer
//  Description : HSI transmit frame sequencer. Requests payload bytes from
//                the SDP source, then CRC bytes from the CRC generator, and
//                loads each granted byte into the serializer. Each source
//                response is supervised by a wait timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module hsi_tx_sequencer #(
    parameter int LEN_W     = 8,
    parameter int CRC_BYTES = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             abort,
    input  logic             ser_busy,
    input  logic             d_rdy,
    output logic [1:0]       tx_state,
    output logic             sdp_req,
    output logic             crc_req,
    output logic             ser_load,
    output logic             crc_init,
    output logic             crc_en,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int c_wait_w = $clog2(TIMEOUT + 1);
    localparam int c_crc_w  = 3;

    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT - 1);
    localparam logic [c_crc_w-1:0]  c_crc_load  = c_crc_w'(CRC_BYTES);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_sdp_req  = 3'd1;
    localparam logic [2:0] c_st_sdp_wait = 3'd2;
    localparam logic [2:0] c_st_crc_req  = 3'd3;
    localparam logic [2:0] c_st_crc_wait = 3'd4;
    localparam logic [2:0] c_st_fin      = 3'd5;

    localparam logic [1:0] c_tx_idle = 2'b00;
    localparam logic [1:0] c_tx_sdp  = 2'b01;
    localparam logic [1:0] c_tx_crc  = 2'b10;

    logic [2:0]          r_state;
    logic [1:0]          r_tx_state;
    logic [LEN_W-1:0]    r_byte_cnt;
    logic [c_crc_w-1:0]  r_crc_cnt;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic                r_crc_init;
    logic                r_busy;
    logic                r_err;

    logic w_sdp_wait;
    logic w_crc_wait;
    logic w_timeout;

    assign w_sdp_wait = (r_state == c_st_sdp_wait);
    assign w_crc_wait = (r_state == c_st_crc_wait);
    assign w_timeout  = (r_wait_cnt == c_wait_last);

    // The first SDP request is held off while crc_init is high so the CRC
    // generator is always cleared strictly before the first payload request.
    assign sdp_req  = (r_state == c_st_sdp_req) && !ser_busy && !abort && !r_crc_init;
    assign crc_req  = (r_state == c_st_crc_req) && !ser_busy && !abort;
    // Abort wins over a byte arriving in the same cycle.
    assign ser_load = (w_sdp_wait || w_crc_wait) && d_rdy && !abort;
    assign crc_en   = w_sdp_wait && d_rdy && !abort;
    assign done     = (r_state == c_st_fin) && !ser_busy && !abort;

    assign tx_state = r_tx_state;
    assign crc_init = r_crc_init;
    assign busy     = r_busy;
    assign err      = r_err;

    // Frame sequencing FSM with registered tx_state / busy / crc_init / err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_tx_state <= c_tx_idle;
            r_byte_cnt <= '0;
            r_crc_cnt  <= '0;
            r_wait_cnt <= '0;
            r_crc_init <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_crc_init <= 1'b0;
            r_err      <= 1'b0;
            if ((r_state != c_st_idle) && abort) begin
                r_state    <= c_st_idle;
                r_tx_state <= c_tx_idle;
                r_busy     <= 1'b0;
                r_err      <= 1'b1;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (start && (frame_len != '0)) begin
                            r_byte_cnt <= frame_len;
                            r_crc_init <= 1'b1;
                            r_state    <= c_st_sdp_req;
                            r_tx_state <= c_tx_sdp;
                            r_busy     <= 1'b1;
                        end
                    end
                    c_st_sdp_req: begin
                        if (sdp_req) begin
                            r_state    <= c_st_sdp_wait;
                            r_wait_cnt <= '0;
                        end
                    end
                    c_st_sdp_wait: begin
                        if (d_rdy) begin
                            r_byte_cnt <= r_byte_cnt - LEN_W'(1);
                            if (r_byte_cnt == LEN_W'(1)) begin
                                r_state    <= c_st_crc_req;
                                r_tx_state <= c_tx_crc;
                                r_crc_cnt  <= c_crc_load;
                            end else begin
                                r_state <= c_st_sdp_req;
                            end
                        end else if (w_timeout) begin
                            r_state    <= c_st_idle;
                            r_tx_state <= c_tx_idle;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + c_wait_w'(1);
                        end
                    end
                    c_st_crc_req: begin
                        if (crc_req) begin
                            r_state    <= c_st_crc_wait;
                            r_wait_cnt <= '0;
                        end
                    end
                    c_st_crc_wait: begin
                        if (d_rdy) begin
                            r_crc_cnt <= r_crc_cnt - c_crc_w'(1);
                            if (r_crc_cnt == c_crc_w'(1)) begin
                                r_state    <= c_st_fin;
                                r_tx_state <= c_tx_idle;
                            end else begin
                                r_state <= c_st_crc_req;
                            end
                        end else if (w_timeout) begin
                            r_state    <= c_st_idle;
                            r_tx_state <= c_tx_idle;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + c_wait_w'(1);
                        end
                    end
                    c_st_fin: begin
                        // Hold until the last byte has left the serializer.
                        if (!ser_busy) begin
                            r_state <= c_st_idle;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state    <= c_st_idle;
                        r_tx_state <= c_tx_idle;
                        r_busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hsi_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hsi_tx_sequencer
//  Description : Self-checking bench for hsi_tx_sequencer. A frame table is
//                replayed against a simple source/serializer model, followed
//                by hand-written timeout, abort, ignore-start, serializer
//                back-pressure and mid-frame reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hsi_tx_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] frame_len = 8'd0;
    logic       abort = 1'b0;
    logic       ser_busy = 1'b0;
    logic       d_rdy = 1'b0;
    logic [1:0] tx_state;
    logic       sdp_req, crc_req, ser_load, crc_init, crc_en, busy, done, err;

    hsi_tx_sequencer #(.LEN_W(8), .CRC_BYTES(2), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
        .abort(abort), .ser_busy(ser_busy), .d_rdy(d_rdy),
        .tx_state(tx_state), .sdp_req(sdp_req), .crc_req(crc_req),
        .ser_load(ser_load), .crc_init(crc_init), .crc_en(crc_en),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Per-run observations
    int n_load, n_crc_en, n_init, n_sdp, n_crc, n_bad, n_done, n_err;
    int n_sdp_req, n_crc_req, req_busy, done_busy, init_viol, load_at_abort;
    int last_load, done_cyc, err_cyc, abort_cyc, end_cyc, busy_after, ended;
    int req_cyc[8];
    int nreq;

    // Drives one frame: start in cycle 0, source answers dly cycles after a
    // request (only the first resp_limit requests), serializer stays busy
    // sbusy cycles after each load.
    task automatic run_frame(input int len, input int dly, input int sbusy,
                             input int resp_limit, input int abort_crc,
                             input int rst_at, input int restart_at,
                             input int budget);
        int rdy_at, busy_left, aborted;
        n_load = 0; n_crc_en = 0; n_init = 0; n_sdp = 0; n_crc = 0; n_bad = 0;
        n_done = 0; n_err = 0; n_sdp_req = 0; n_crc_req = 0; req_busy = 0;
        done_busy = 0; init_viol = 0; load_at_abort = 0; nreq = 0;
        last_load = -1; done_cyc = -1; err_cyc = -1; abort_cyc = -1;
        end_cyc = -1; busy_after = -1; ended = 0;
        rdy_at = -1; busy_left = 0; aborted = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            start     = (c == 0) || (c == restart_at);
            frame_len = (c == 0) ? len[7:0] : 8'd7;
            ser_busy  = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            d_rdy = (rdy_at == c);
            abort = 1'b0;
            if (abort_crc != 0 && d_rdy && tx_state == 2'b10 && aborted == 0) begin
                abort = 1'b1; aborted = 1; abort_cyc = c;
            end
            if (c == rst_at) begin
                d_rdy = 1'b0; start = 1'b0;
                rst_n = 1'b0;
                #1;
                check("reset_midframe_outputs",
                      int'({tx_state, sdp_req, crc_req, ser_load, crc_init,
                            crc_en, busy, done, err}), 0);
                ended = 1;
                break;
            end
            #1;
            if (sdp_req || crc_req) begin
                if (nreq < 8) req_cyc[nreq] = c;
                nreq++;
                if (ser_busy) req_busy++;
                if (nreq <= resp_limit) rdy_at = c + dly;
            end
            if (sdp_req) begin
                n_sdp_req++;
                if (n_init == 0 || crc_init) init_viol++;
            end
            if (crc_req) n_crc_req++;
            if (crc_init) n_init++;
            if (ser_load) begin n_load++; last_load = c; busy_left = sbusy; end
            if (abort && ser_load) load_at_abort++;
            if (crc_en) n_crc_en++;
            if (tx_state == 2'b01) n_sdp++;
            if (tx_state == 2'b10) n_crc++;
            if (tx_state == 2'b11) n_bad++;
            if (done) begin n_done++; done_cyc = c; if (ser_busy) done_busy++; end
            if (err) begin n_err++; err_cyc = c; end
            if (end_cyc >= 0 && c == end_cyc + 1) begin
                busy_after = int'(busy); ended = 1; break;
            end
            if (end_cyc < 0 && (done || err)) end_cyc = c;
        end
        start = 1'b0; abort = 1'b0; d_rdy = 1'b0; ser_busy = 1'b0; frame_len = 8'd0;
        if (rst_at < 0) check("frame_end_within_budget", ended, 1);
    endtask

    typedef struct {
        int len;
        int dly;
        int loads;
        int crc_ens;
        int sdp_cyc;
        int crc_cyc;
    } vec_t;

    vec_t vecs[4];

    initial begin
        // len, source delay, loads, crc_en, cycles tx=01, cycles tx=10
        vecs[0] = '{3, 1, 5, 3,  7, 4};
        vecs[1] = '{1, 1, 3, 1,  3, 4};
        vecs[2] = '{5, 3, 7, 5, 21, 8};
        vecs[3] = '{2, 2, 4, 2,  7, 6};

        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs",
              int'({tx_state, sdp_req, crc_req, ser_load, crc_init,
                    crc_en, busy, done, err}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven normal frames
        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i].len, vecs[i].dly, 0, 99, 0, -1, -1, 200);
            check($sformatf("v%0d_loads", i), n_load, vecs[i].loads);
            check($sformatf("v%0d_crc_en", i), n_crc_en, vecs[i].crc_ens);
            check($sformatf("v%0d_sdp_cycles", i), n_sdp, vecs[i].sdp_cyc);
            check($sformatf("v%0d_crc_cycles", i), n_crc, vecs[i].crc_cyc);
            check($sformatf("v%0d_crc_init", i), n_init, 1);
            check($sformatf("v%0d_init_before_req", i), init_viol, 0);
            check($sformatf("v%0d_done", i), n_done, 1);
            check($sformatf("v%0d_done_latency", i), done_cyc - last_load, 1);
            check($sformatf("v%0d_err", i), n_err, 0);
            check($sformatf("v%0d_busy_after_done", i), busy_after, 0);
            check($sformatf("v%0d_tx_state_11", i), n_bad, 0);
            repeat (2) @(negedge clk);
        end

        // Serializer back-pressure: 10 busy cycles after every load
        run_frame(1, 1, 10, 99, 0, -1, -1, 300);
        check("bp_loads", n_load, 3);
        check("bp_req_while_busy", req_busy, 0);
        check("bp_done_while_busy", done_busy, 0);
        check("bp_done_latency", done_cyc - last_load, 11);
        check("bp_done", n_done, 1);
        repeat (2) @(negedge clk);

        // Timeout: source stops answering after the first request
        run_frame(4, 1, 0, 1, 0, -1, -1, 200);
        check("to_err", n_err, 1);
        check("to_err_after_req", err_cyc - req_cyc[1], 65);
        check("to_loads", n_load, 1);
        check("to_crc_req", n_crc_req, 0);
        check("to_done", n_done, 0);
        check("to_busy_after", busy_after, 0);
        check("to_tx_state_idle", int'(tx_state), 0);
        repeat (2) @(negedge clk);

        // Abort coinciding with d_rdy in CRC_WAIT
        run_frame(1, 1, 0, 99, 1, -1, -1, 100);
        check("ab_load_in_abort_cycle", load_at_abort, 0);
        check("ab_loads", n_load, 1);
        check("ab_err_next_cycle", err_cyc - abort_cyc, 1);
        check("ab_done", n_done, 0);
        check("ab_busy_after", busy_after, 0);
        repeat (2) @(negedge clk);

        // start with frame_len = 0 is ignored
        begin
            int act;
            act = 0;
            @(negedge clk);
            start = 1'b1; frame_len = 8'd0;
            for (int c = 0; c < 6; c++) begin
                #1;
                if (busy || crc_init || sdp_req || tx_state != 2'b00 || err) act++;
                @(negedge clk);
                start = 1'b0;
            end
            check("len0_no_activity", act, 0);
        end

        // start during an active frame is ignored
        run_frame(2, 1, 0, 99, 0, -1, 4, 200);
        check("restart_loads", n_load, 4);
        check("restart_crc_init", n_init, 1);
        check("restart_done", n_done, 1);
        repeat (2) @(negedge clk);

        // Reset while the second of five payload bytes is outstanding
        run_frame(5, 2, 0, 99, 0, 6, -1, 100);
        check("rst_loads_before", n_load, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(2, 1, 0, 99, 0, -1, -1, 200);
        check("post_rst_loads", n_load, 4);
        check("post_rst_done", n_done, 1);
        check("post_rst_err", n_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
